// File: rtl/stepdir_pkg.sv
// rtl/stepdir_pkg.sv - shared widths, axis state type and period helper for the step/dir generator
package stepdir_pkg;
    localparam int POS_W = 32;
    localparam int VEL_W = 32;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW} axis_state_t;

    // Shortest legal period: the pulse itself, the dir hold after it, and one low cycle.
    function automatic logic [CNT_W-1:0] min_period(input int pulse_len, input int dir_hold);
        return CNT_W'(pulse_len + dir_hold + 1);
    endfunction
endpackage

// File: rtl/stepdir_multi_if.sv
// rtl/stepdir_multi_if.sv - host command / pin-side bundle for stepdir_multi
// master: drives velocity, enable, error; observes step, dir, en, position
// slave : the generator itself
interface stepdir_multi_if #(parameter int NUM_AXES = 3);
    import stepdir_pkg::VEL_W;
    import stepdir_pkg::POS_W;

    logic [VEL_W*NUM_AXES-1:0] velocity;
    logic [NUM_AXES-1:0]       enable;
    logic                      error;
    logic [NUM_AXES-1:0]       step;
    logic [NUM_AXES-1:0]       dir;
    logic [NUM_AXES-1:0]       en;
    logic [POS_W*NUM_AXES-1:0] position;

    modport master (output velocity, enable, error, input step, dir, en, position);
    modport slave  (input velocity, enable, error, output step, dir, en, position);
endinterface

// File: rtl/stepdir_axis.sv
// rtl/stepdir_axis.sv - single-axis step/dir FSM with period counter and position counter
// clk, rst  : clock, async active-high reset
// active_en : registered, fault-gated enable for this axis
// velocity  : signed period command (|v| cycles per step, sign = dir, 0 = stop)
// step, dir : pin outputs; position : signed step count
module stepdir_axis import stepdir_pkg::*; #(
    parameter int PULSE_CYC = 27,
    parameter int SETUP_CYC = 27,
    parameter int HOLD_CYC  = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active_en,
    input  logic [VEL_W-1:0] velocity,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] position
);
    localparam logic [CNT_W-1:0] MIN_P      = min_period(PULSE_CYC, HOLD_CYC);
    localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    // cnt is measured from the rising edge, so the hold window closes PULSE+HOLD cycles after it.
    localparam logic [CNT_W-1:0] HOLD_DONE  = CNT_W'(PULSE_CYC + HOLD_CYC - 1);

    axis_state_t      state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;
    logic             step_d, step_q, dir_d, dir_q;
    logic [POS_W-1:0] pos_d, pos_q, pos_step;
    logic [VEL_W:0]   mag, period, thresh;
    logic             dir_req, active, due, hold_ok;

    always_comb begin
        // 33-bit magnitude so that -2^31 yields 2^31 without overflow.
        mag      = velocity[VEL_W-1] ? ({1'b0, ~velocity} + 33'd1) : {1'b0, velocity};
        period   = (mag < {1'b0, MIN_P}) ? {1'b0, MIN_P} : mag;
        thresh   = period - 33'd1;
        due      = {1'b0, cnt_q} >= thresh;
        hold_ok  = cnt_q >= HOLD_DONE;
        dir_req  = ~velocity[VEL_W-1];
        active   = active_en && (velocity != '0);
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        pos_step = dir_q ? POS_W'(1) : '1;

        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        case (state_q)
            IDLE: begin
                step_d = 1'b0;
                if (active) begin
                    if (dir_req != dir_q) begin
                        state_d = DIR_SETUP;
                        dir_d   = dir_req;
                        cnt_d   = '0;
                    end else begin
                        // Saturated count makes the first step due immediately.
                        state_d = STEP_LOW;
                        cnt_d   = '1;
                    end
                end
            end
            DIR_SETUP: begin
                if (!active) begin
                    state_d = IDLE;
                end else if (dir_req != dir_q) begin
                    dir_d = dir_req;
                    cnt_d = '0;
                end else if (cnt_q >= SETUP_LAST) begin
                    state_d = STEP_HIGH;
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    pos_d   = pos_q + pos_step;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STEP_HIGH: begin
                // Pulse always runs to full width regardless of enable or velocity.
                cnt_d = cnt_inc;
                if (cnt_q >= HIGH_LAST) begin
                    state_d = STEP_LOW;
                    step_d  = 1'b0;
                end
            end
            STEP_LOW: begin
                cnt_d = cnt_inc;
                if (!active) begin
                    if (hold_ok) state_d = IDLE;
                end else if (dir_req != dir_q) begin
                    if (hold_ok) begin
                        state_d = DIR_SETUP;
                        dir_d   = dir_req;
                        cnt_d   = '0;
                    end
                end else if (due) begin
                    state_d = STEP_HIGH;
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    pos_d   = pos_q + pos_step;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign position = pos_q;
endmodule

// File: rtl/stepdir_multi.sv
// rtl/stepdir_multi.sv - N-axis step/dir pulse generator with shared fault gating
// clk, rst : system clock, async active-high reset
// bus      : velocity/enable/error in; step/dir/en/position out (per-axis slices of 32 bits)
module stepdir_multi #(
    parameter int NUM_AXES  = 3,
    parameter int PULSE_LEN = 27,
    parameter int DIR_SETUP = 27,
    parameter int DIR_HOLD  = 27
) (
    input  logic           clk,
    input  logic           rst,
    stepdir_multi_if.slave bus
);
    import stepdir_pkg::VEL_W;
    import stepdir_pkg::POS_W;

    logic [NUM_AXES-1:0]       en_d, en_q;
    logic [NUM_AXES-1:0]       step_w, dir_w;
    logic [POS_W*NUM_AXES-1:0] pos_w;

    always_comb en_d = bus.enable & {NUM_AXES{~bus.error}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) en_q <= '0;
        else     en_q <= en_d;
    end

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        stepdir_axis #(
            .PULSE_CYC (PULSE_LEN),
            .SETUP_CYC (DIR_SETUP),
            .HOLD_CYC  (DIR_HOLD)
        ) u_axis (
            .clk       (clk),
            .rst       (rst),
            .active_en (en_q[i]),
            .velocity  (bus.velocity[VEL_W*i +: VEL_W]),
            .step      (step_w[i]),
            .dir       (dir_w[i]),
            .position  (pos_w[POS_W*i +: POS_W])
        );
    end

    assign bus.en       = en_q;
    assign bus.step     = step_w;
    assign bus.dir      = dir_w;
    assign bus.position = pos_w;
endmodule

// File: tb/tb_stepdir_multi.sv
// tb/tb_stepdir_multi.sv - self-checking bench for stepdir_multi
module tb_stepdir_multi;
    localparam int PL = 27, DS = 27, DH = 27, MINP = PL + DH + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    stepdir_multi_if #(.NUM_AXES(3)) bus ();
    stepdir_multi #(.NUM_AXES(3), .PULSE_LEN(PL), .DIR_SETUP(DS), .DIR_HOLD(DH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0, n_fail = 0;
    int cyc_n = 0;
    logic [2:0] en_exp = '0, prev_step = '0, prev_dir = '0, prev_en = '0;
    int high_len[3], last_high[3], last_rise[3], last_fall[3], last_dchg[3], rise_cnt[3], last_spacing[3];
    logic [31:0] model_pos[3];
    logic preset2 = 1'b0;
    logic [31:0] snap[3];
    int rc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pos_of(input int ax);
        return bus.position[32*ax +: 32];
    endfunction

    // Spec-level checks on every cycle: en latency, pulse width, dir setup/hold,
    // minimum period, no step without enable, position = signed count of observed steps.
    task automatic mon();
        logic s, d;
        cyc_n++;
        if (rst) begin
            chk("reset_outputs", {bus.step, bus.dir, bus.en}, 0);
            chk("reset_position", (bus.position == '0), 1);
            for (int i = 0; i < 3; i++) begin
                high_len[i] = 0; last_high[i] = 0; last_rise[i] = -1; last_fall[i] = -1000000;
                last_dchg[i] = -1000000; rise_cnt[i] = 0; last_spacing[i] = 0; model_pos[i] = 0;
            end
            prev_step = '0; prev_dir = '0; prev_en = '0; en_exp = '0;
        end else begin
            chk("en_latency", bus.en, en_exp);
            for (int i = 0; i < 3; i++) begin
                s = bus.step[i];
                d = bus.dir[i];
                if (preset2 && i == 2) model_pos[2] = 32'h7FFF_FFFF;
                if (s && !prev_step[i]) begin
                    chk("step_needs_enable", prev_en[i], 1);
                    chk("dir_setup_time", (cyc_n - last_dchg[i] >= DS), 1);
                    if (last_rise[i] >= 0) begin
                        last_spacing[i] = cyc_n - last_rise[i];
                        chk("min_period", (last_spacing[i] >= MINP), 1);
                    end
                    last_rise[i] = cyc_n;
                    rise_cnt[i]++;
                    model_pos[i] = d ? model_pos[i] + 32'd1 : model_pos[i] - 32'd1;
                    high_len[i] = 0;
                end
                if (s) high_len[i]++;
                if (!s && prev_step[i]) begin
                    chk("pulse_width", high_len[i], PL);
                    last_high[i] = high_len[i];
                    last_fall[i] = cyc_n;
                end
                if (d != prev_dir[i]) begin
                    chk("dir_change_while_high", s, 0);
                    chk("dir_hold_time", (cyc_n - last_fall[i] >= DH), 1);
                    last_dchg[i] = cyc_n;
                end
                chk("position_tracks_steps", pos_of(i), model_pos[i]);
            end
            prev_step = bus.step;
            prev_dir  = bus.dir;
            prev_en   = bus.en;
            en_exp    = bus.enable & ~{3{bus.error}};
        end
    endtask

    task automatic wait_rise(input int ax, input int max_cyc);
        int c0, k;
        c0 = rise_cnt[ax];
        k = 0;
        while (rise_cnt[ax] == c0 && k < max_cyc) begin
            cyc();
            k++;
        end
        chk("rise_timeout", (rise_cnt[ax] != c0), 1);
    endtask

    initial begin
        bus.velocity = '0;
        bus.enable   = '0;
        bus.error    = 1'b0;
        fork
            forever begin
                @(negedge clk);
                mon();
            end
            begin
                repeat (3) cyc();
                chk("reset_step", bus.step, 0);
                chk("reset_en", bus.en, 0);
                rst = 1'b0;
                cyc();

                // 1: axis 0 at +270 for 2700 cycles
                bus.velocity[31:0] = 32'd270;
                bus.enable = 3'b001;
                repeat (2700) cyc();
                chk("t1_steps", rise_cnt[0], 10);
                chk("t1_spacing", last_spacing[0], 270);
                chk("t1_width", last_high[0], 27);
                chk("t1_pos0", pos_of(0), 10);
                chk("t1_dir0", bus.dir[0], 1);
                chk("t1_idle_steps", rise_cnt[1] + rise_cnt[2], 0);
                chk("t1_idle_pos", {pos_of(1), pos_of(2)}, 0);

                // 2: reverse right after a rising edge
                wait_rise(0, 400);
                chk("t2_pos_before", pos_of(0), 11);
                bus.velocity[31:0] = -32'sd270;
                wait_rise(0, 400);
                chk("t2_rev_spacing", last_spacing[0], 81);
                chk("t2_hold", last_dchg[0] - last_fall[0], 27);
                chk("t2_setup", last_rise[0] - last_dchg[0], 27);
                chk("t2_dir0", bus.dir[0], 0);
                chk("t2_pos_down1", pos_of(0), 10);
                wait_rise(0, 400);
                chk("t2_spacing", last_spacing[0], 270);
                chk("t2_pos_down2", pos_of(0), 9);

                // 3: clamp below minimum, then most negative velocity
                bus.velocity[63:32] = 32'd5;
                bus.enable = 3'b011;
                repeat (3) wait_rise(1, 200);
                chk("t3_clamped", last_spacing[1], 55);
                chk("t3_pos1", pos_of(1), 3);
                bus.velocity[63:32] = 32'h8000_0000;
                wait_rise(1, 200);
                chk("t3_rev_spacing", last_spacing[1], 81);
                chk("t3_dir1", bus.dir[1], 0);
                chk("t3_pos1_down", pos_of(1), 2);
                rc = rise_cnt[1];
                repeat (3000) cyc();
                chk("t3_no_more_steps", rise_cnt[1], rc);
                bus.enable = 3'b001;
                bus.velocity[63:32] = '0;

                // 4: error three cycles into a pulse
                wait_rise(0, 400);
                cyc();
                bus.error = 1'b1;
                for (int i = 0; i < 3; i++) snap[i] = model_pos[i];
                rc = rise_cnt[0];
                cyc();
                chk("t4_en_off", bus.en, 3'b000);
                repeat (600) cyc();
                chk("t4_width", last_high[0], 27);
                chk("t4_no_steps", rise_cnt[0], rc);
                chk("t4_pos0_kept", pos_of(0), snap[0]);
                chk("t4_pos1_kept", pos_of(1), snap[1]);
                bus.error = 1'b0;
                cyc();
                chk("t4_en_back", bus.en, 3'b001);
                wait_rise(0, 20);
                chk("t4_resume_pos", pos_of(0), snap[0] - 32'd1);

                // 5: position wrap on axis 2
                preset2 = 1'b1;
                force dut.g_axis[2].u_axis.pos_q = 32'h7FFF_FFFF;
                cyc();
                release dut.g_axis[2].u_axis.pos_q;
                cyc();
                preset2 = 1'b0;
                chk("t5_preset_kept", pos_of(2), 32'h7FFF_FFFF);
                bus.velocity[95:64] = 32'd55;
                bus.enable = 3'b101;
                wait_rise(2, 100);
                chk("t5_wrap", pos_of(2), 32'h8000_0000);
                wait_rise(2, 100);
                chk("t5_spacing", last_spacing[2], 55);
                chk("t5_after_wrap", pos_of(2), 32'h8000_0001);

                // 6: reset at cycle 10 of a pulse
                wait_rise(0, 400);
                repeat (8) cyc();
                chk("t6_pre_reset_high", bus.step[0], 1);
                #4 rst = 1'b1;
                #1;
                chk("t6_async_step", bus.step, 0);
                chk("t6_async_dir", bus.dir, 0);
                chk("t6_async_en", bus.en, 0);
                chk("t6_async_pos", (bus.position == '0), 1);
                bus.velocity = '0;
                bus.enable = '0;
                repeat (3) cyc();
                rst = 1'b0;
                repeat (5) cyc();
                chk("t6_post_outputs", {bus.step, bus.dir, bus.en}, 0);
                chk("t6_post_pos", (bus.position == '0), 1);

                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        join_any
    end
endmodule
